// File: rtl/reg_writeback_ctrl_if.sv
// Bus bundle for the writeback queue: pipeline handshake, register-file
// write port, forwarding lookup ports and occupancy.
interface reg_writeback_ctrl_if #(
    parameter int DEPTH = 4,
    parameter int AW    = 6,
    parameter int DW    = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          wb_valid;
    logic          wb_ready;
    logic [AW-1:0] wb_rd;
    logic [DW-1:0] wb_data;
    logic          drain_en;
    logic [AW-1:0] writereg;
    logic [DW-1:0] writedata;
    logic          wen;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic          fwd1_hit;
    logic          fwd2_hit;
    logic [DW-1:0] fwd1_data;
    logic [DW-1:0] fwd2_data;
    logic [CW-1:0] count;

    modport master (
        output wb_valid, wb_rd, wb_data, drain_en, rs1, rs2,
        input  wb_ready, writereg, writedata, wen,
               fwd1_hit, fwd2_hit, fwd1_data, fwd2_data, count
    );

    modport slave (
        input  wb_valid, wb_rd, wb_data, drain_en, rs1, rs2,
        output wb_ready, writereg, writedata, wen,
               fwd1_hit, fwd2_hit, fwd1_data, fwd2_data, count
    );
endinterface

// File: rtl/reg_writeback_ctrl.sv
// Pending-writeback FIFO between the pipeline and the register file, with a
// registered write port and youngest-first forwarding over pending writes.
module reg_writeback_ctrl #(
    parameter int DEPTH = 4,
    parameter int AW    = 6,
    parameter int DW    = 32
) (
    input logic                 clk,
    input logic                 rst,
    reg_writeback_ctrl_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] rd_q   [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] cnt;
    logic          ready;
    logic          push;
    logic          pop;
    logic [AW-1:0] wreg;
    logic [DW-1:0] wdata;
    logic          wen_r;

    // Writes to x0 complete the handshake but never occupy a slot.
    assign ready = (cnt < CW'(DEPTH));
    assign push  = bus.wb_valid && ready && (bus.wb_rd != '0);
    assign pop   = bus.drain_en && (cnt != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            cnt   <= '0;
            wen_r <= 1'b0;
            wreg  <= '0;
            wdata <= '0;
        end else begin
            if (push) begin
                tail <= tail + PW'(1);
            end
            if (pop) begin
                head  <= head + PW'(1);
                wreg  <= rd_q[head];
                wdata <= data_q[head];
            end
            wen_r <= pop;
            cnt   <= cnt + CW'(push) - CW'(pop);
        end
    end

    // Slot contents are only meaningful while the pointers mark them occupied.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_q[tail]   <= bus.wb_rd;
            data_q[tail] <= bus.wb_data;
        end
    end

    logic [1:0][AW-1:0] rs;
    logic [1:0]         hit;
    logic [1:0][DW-1:0] fdata;

    assign rs = {bus.rs2, bus.rs1};

    // Output stage first, then queued entries oldest to youngest so the
    // youngest matching entry is the last one to win.
    always_comb begin : fwd_lookup
        logic [PW-1:0] idx;
        idx   = '0;
        hit   = '0;
        fdata = '0;
        for (int p = 0; p < 2; p++) begin
            if (wen_r && (wreg == rs[p])) begin
                hit[p]   = 1'b1;
                fdata[p] = wdata;
            end
            for (int i = 0; i < DEPTH; i++) begin
                idx = head + PW'(i);
                if ((CW'(i) < cnt) && (rd_q[idx] == rs[p])) begin
                    hit[p]   = 1'b1;
                    fdata[p] = data_q[idx];
                end
            end
            if (rs[p] == '0) begin
                hit[p]   = 1'b0;
                fdata[p] = '0;
            end
        end
    end

    assign bus.wb_ready  = ready;
    assign bus.count     = cnt;
    assign bus.wen       = wen_r;
    assign bus.writereg  = wreg;
    assign bus.writedata = wdata;
    assign bus.fwd1_hit  = hit[0];
    assign bus.fwd2_hit  = hit[1];
    assign bus.fwd1_data = fdata[0];
    assign bus.fwd2_data = fdata[1];
endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Directed bench for reg_writeback_ctrl: a queue-based reference model checked
// every negedge, plus literal expectations for the documented scenarios.
module tb_reg_writeback_ctrl;
    localparam int DEPTH = 4;
    localparam int AW    = 6;
    localparam int DW    = 32;

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } entry_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   wen_pulses;
    int   base;

    entry_t        mq[$];
    logic          m_wen;
    logic [AW-1:0] m_reg;
    logic [DW-1:0] m_data;

    reg_writeback_ctrl_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

    reg_writeback_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_wen  = 1'b0;
        m_reg  = '0;
        m_data = '0;
    endtask

    // Applies one clock edge to the model from the inputs the bench is driving.
    task automatic model_step();
        bit     push;
        bit     pop;
        entry_t e;
        if (rst) return;
        push = bus.wb_valid && (mq.size() < DEPTH) && (bus.wb_rd != 0);
        pop  = bus.drain_en && (mq.size() > 0);
        if (pop) begin
            e      = mq.pop_front();
            m_wen  = 1'b1;
            m_reg  = e.rd;
            m_data = e.data;
        end else begin
            m_wen = 1'b0;
        end
        if (push) mq.push_back('{rd: bus.wb_rd, data: bus.wb_data});
    endtask

    function automatic void model_fwd(input logic [AW-1:0] r, output logic h, output logic [DW-1:0] d);
        h = 1'b0;
        d = '0;
        if (r == 0) return;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].rd == r) begin
                h = 1'b1;
                d = mq[i].data;
                return;
            end
        end
        if (m_wen && (m_reg == r)) begin
            h = 1'b1;
            d = m_data;
        end
    endfunction

    always @(negedge clk) begin : compare
        logic          h1;
        logic          h2;
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
        model_fwd(bus.rs1, h1, d1);
        model_fwd(bus.rs2, h2, d2);
        chk("m_count", 64'(bus.count), 64'(mq.size()));
        chk("m_wb_ready", 64'(bus.wb_ready), 64'(mq.size() < DEPTH));
        chk("m_wen", 64'(bus.wen), 64'(m_wen));
        chk("m_writereg", 64'(bus.writereg), 64'(m_reg));
        chk("m_writedata", 64'(bus.writedata), 64'(m_data));
        chk("m_fwd1_hit", 64'(bus.fwd1_hit), 64'(h1));
        chk("m_fwd1_data", 64'(bus.fwd1_data), 64'(d1));
        chk("m_fwd2_hit", 64'(bus.fwd2_hit), 64'(h2));
        chk("m_fwd2_data", 64'(bus.fwd2_data), 64'(d2));
        if (bus.wen) wen_pulses++;
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #2;
    endtask

    logic [AW-1:0] fill_rd [4];
    logic [DW-1:0] fill_dt [4];

    initial begin
        checks = 0; errors = 0; wen_pulses = 0; base = 0;
        fill_rd = '{6'd2, 6'd3, 6'd16, 6'd5};
        fill_dt = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h1111_1111, 32'h0000_0005};
        rst = 1'b1;
        bus.wb_valid = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;
        bus.drain_en = 1'b0; bus.rs1 = '0; bus.rs2 = '0;
        model_reset();
        tick(); tick();
        chk("rst_count", 64'(bus.count), 64'd0);
        chk("rst_wen", 64'(bus.wen), 64'd0);
        chk("rst_ready", 64'(bus.wb_ready), 64'd1);
        chk("rst_writereg", 64'(bus.writereg), 64'd0);
        rst = 1'b0;
        tick();

        // Single write: accepted at edge 1, retired after edge 2.
        bus.wb_valid = 1'b1; bus.wb_rd = 6'd1; bus.wb_data = 32'h2; bus.drain_en = 1'b1;
        tick();
        bus.wb_valid = 1'b0;
        chk("t1_count_e1", 64'(bus.count), 64'd1);
        chk("t1_wen_e1", 64'(bus.wen), 64'd0);
        tick();
        chk("t1_wen_e2", 64'(bus.wen), 64'd1);
        chk("t1_reg_e2", 64'(bus.writereg), 64'd1);
        chk("t1_data_e2", 64'(bus.writedata), 64'h2);
        tick();
        chk("t1_wen_e3", 64'(bus.wen), 64'd0);

        // Fill, stall, then drain with a rejected push on the first pop edge.
        bus.drain_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.wb_valid = 1'b1; bus.wb_rd = fill_rd[i]; bus.wb_data = fill_dt[i];
            tick();
        end
        chk("fill_count", 64'(bus.count), 64'd4);
        chk("fill_ready", 64'(bus.wb_ready), 64'd0);
        bus.wb_rd = 6'd9; bus.wb_data = 32'h99;
        tick();
        chk("fill_5th_count", 64'(bus.count), 64'd4);
        bus.drain_en = 1'b1;
        #1;
        chk("full_pop_ready", 64'(bus.wb_ready), 64'd0);
        tick();
        bus.wb_valid = 1'b0;
        chk("drain_count", 64'(bus.count), 64'd3);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            chk("drain_wen", 64'(bus.wen), 64'd1);
            chk("drain_reg", 64'(bus.writereg), 64'(fill_rd[i]));
            chk("drain_data", 64'(bus.writedata), 64'(fill_dt[i]));
        end
        tick();
        chk("drain_end_wen", 64'(bus.wen), 64'd0);
        chk("drain_end_count", 64'(bus.count), 64'd0);

        // Forwarding: youngest queued entry wins, then the output stage.
        bus.drain_en = 1'b0;
        bus.wb_valid = 1'b1; bus.wb_rd = 6'd2; bus.wb_data = 32'hA;
        tick();
        bus.wb_data = 32'hB;
        tick();
        bus.wb_valid = 1'b0; bus.rs1 = 6'd2; bus.rs2 = 6'd7;
        #1;
        chk("fwd1_hit", 64'(bus.fwd1_hit), 64'd1);
        chk("fwd1_data", 64'(bus.fwd1_data), 64'hB);
        chk("fwd2_hit_miss", 64'(bus.fwd2_hit), 64'd0);
        chk("fwd2_data_miss", 64'(bus.fwd2_data), 64'd0);
        bus.wb_valid = 1'b1; bus.wb_rd = 6'd7; bus.wb_data = 32'h77;
        #1;
        chk("fwd2_inflight", 64'(bus.fwd2_hit), 64'd0);
        tick();
        bus.wb_valid = 1'b0;
        chk("fwd2_after_edge", 64'(bus.fwd2_hit), 64'd1);
        chk("fwd2_after_data", 64'(bus.fwd2_data), 64'h77);
        bus.drain_en = 1'b1; bus.rs2 = 6'd0;
        tick();
        chk("fwd1_queue_over_out", 64'(bus.fwd1_data), 64'hB);
        chk("fwd2_rs0", 64'(bus.fwd2_hit), 64'd0);
        tick();
        chk("fwd1_outstage_hit", 64'(bus.fwd1_hit), 64'd1);
        chk("fwd1_outstage_data", 64'(bus.fwd1_data), 64'hB);
        tick();
        chk("fwd1_gone", 64'(bus.fwd1_hit), 64'd0);
        tick();

        // Writes to x0 are accepted and dropped.
        bus.wb_valid = 1'b1; bus.wb_rd = 6'd0; bus.wb_data = 32'hDEAD_BEEF; bus.rs1 = 6'd0;
        tick();
        bus.wb_valid = 1'b0;
        chk("x0_count", 64'(bus.count), 64'd0);
        tick();
        chk("x0_wen", 64'(bus.wen), 64'd0);
        chk("x0_fwd1", 64'(bus.fwd1_hit), 64'd0);

        // Continuous push and drain across the pointer wrap.
        base = wen_pulses;
        bus.drain_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.wb_valid = 1'b1; bus.wb_rd = AW'(i + 1); bus.wb_data = 32'h100 * (i + 1) + i;
            tick();
            chk("wrap_count", 64'(bus.count), 64'd1);
            if (i > 0) chk("wrap_reg", 64'(bus.writereg), 64'(i));
        end
        bus.wb_valid = 1'b0;
        tick();
        chk("wrap_last_data", 64'(bus.writedata), 64'h0000_0A09);
        tick();
        chk("wrap_pulses", 64'(wen_pulses - base), 64'd10);

        // Asynchronous reset mid-cycle with three entries pending.
        bus.drain_en = 1'b0; bus.rs1 = 6'd4;
        for (int i = 0; i < 4; i++) begin
            bus.wb_valid = 1'b1; bus.wb_rd = AW'(i + 1); bus.wb_data = 32'h40 + i;
            tick();
        end
        bus.wb_valid = 1'b0; bus.drain_en = 1'b1;
        tick();
        chk("ar_pre_count", 64'(bus.count), 64'd3);
        chk("ar_pre_wen", 64'(bus.wen), 64'd1);
        #1;
        rst = 1'b1;
        bus.wb_valid = 1'b1; bus.wb_rd = 6'd6; bus.wb_data = 32'h66;
        model_reset();
        #1;
        chk("ar_count", 64'(bus.count), 64'd0);
        chk("ar_wen", 64'(bus.wen), 64'd0);
        chk("ar_ready", 64'(bus.wb_ready), 64'd1);
        chk("ar_fwd1", 64'(bus.fwd1_hit), 64'd0);
        chk("ar_writereg", 64'(bus.writereg), 64'd0);
        tick(); tick();
        chk("ar_hold_count", 64'(bus.count), 64'd0);
        bus.wb_valid = 1'b0;
        rst = 1'b0;
        base = wen_pulses;
        tick(); tick(); tick();
        chk("ar_no_stale", 64'(wen_pulses - base), 64'd0);
        chk("ar_post_count", 64'(bus.count), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/reg_writeback_ctrl.md
REG_WRITEBACK_CTRL -- requirements
Module: reg_writeback_ctrl

Interface
REQ-001 Parameter DEPTH, 4, number of pending-writeback queue entries; power of two, 2 to 16.
REQ-002 Parameter AW, 6, register-address width.
REQ-003 Parameter DW, 32, register-data width.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, asynchronous and active-high.
REQ-006 wb_valid  in  1  pipeline offers a writeback this cycle.
REQ-007 wb_ready  out  1  queue can accept a writeback this cycle.
REQ-008 wb_rd  in  AW  destination register of the offered writeback.
REQ-009 wb_data  in  DW  data of the offered writeback.
REQ-010 drain_en  in  1  permits retiring one queued entry to the register file this cycle.
REQ-011 writereg  out  AW  register-file write address, registered.
REQ-012 writedata  out  DW  register-file write data, registered.
REQ-013 wen  out  1  register-file write enable, registered, one-cycle pulse per retired entry.
REQ-014 rs1, rs2  in  AW each  read addresses for forwarding lookup.
REQ-015 fwd1_hit, fwd2_hit  out  1 each  a pending write to rs1 or rs2 exists.
REQ-016 fwd1_data, fwd2_data  out  DW each  data of the youngest pending write to rs1 or rs2.
REQ-017 count  out  clog2(DEPTH)+1  number of queued entries; excludes the output stage.

Function
REQ-018 A handshake SHALL occur on a rising edge where wb_valid=1 and wb_ready=1.
REQ-019 wb_ready SHALL equal (count < DEPTH), combinationally; it SHALL NOT depend on wb_valid or drain_en.
REQ-020 A handshake with wb_rd=0 SHALL complete and be discarded: no enqueue, no count change, no wen.
REQ-021 A handshake with wb_rd!=0 SHALL write {wb_rd, wb_data} at the tail, and the tail pointer SHALL wrap modulo DEPTH.
REQ-022 On each edge with drain_en=1 and count>0, the head SHALL load into writereg/writedata, wen SHALL be 1 for the following cycle, and the head pointer SHALL advance, wrapping modulo DEPTH.
REQ-023 On each edge with drain_en=0 or count=0, wen SHALL become 0 and writereg/writedata SHALL hold their values.
REQ-024 Latency: an entry enqueued at edge k into an empty queue with drain_en=1 SHALL present wen=1 in the cycle after edge k+1.
REQ-025 Push and pop on the same edge SHALL leave count unchanged and preserve FIFO order.
REQ-026 When count=DEPTH, wb_ready=0 for the whole cycle, even if a pop occurs on the same edge.
REQ-027 Retirement order SHALL equal acceptance order, and exactly one wen pulse SHALL occur per accepted non-zero entry.
REQ-028 Forwarding SHALL be combinational over the queued entries plus the output stage while wen=1.
REQ-029 Forwarding priority SHALL be the youngest queued entry first, then the output stage.
REQ-030 rsN=0 SHALL force fwdN_hit=0; on fwdN_hit=0, fwdN_data SHALL be 0.
REQ-031 An entry being handshaken in the current cycle SHALL NOT be visible to forwarding until after the edge.

Reset
REQ-032 rst=1 SHALL immediately, without a clock edge, clear the pointers, set count=0, and set wen=0, writereg=0, writedata=0, fwd*_hit=0.
REQ-033 Reset mid-operation SHALL discard all pending entries; no wen pulse SHALL follow for them.
REQ-034 During reset wb_ready SHALL be 1, but handshakes SHALL be ignored until the first edge after rst deasserts.

Verification
REQ-035 Single write: rst, then wb_rd=1, wb_data=0x2, drain_en=1 at edge 1 -> wen=1, writereg=1, writedata=0x00000002 after edge 2; wen=0 after edge 3.
REQ-036 Fill/stall: drain_en=0; push rd 2,3,16,5 with data 0x80000000, 0xFFFFFFFF, 0x11111111, 0x5 -> count=4, wb_ready=0; a fifth push is not accepted; set drain_en=1 -> four wen pulses in order 2,3,16,5, then wen=0, count=0.
REQ-037 Forwarding: drain_en=0; push rd2=0xA then rd2=0xB; rs1=2 -> fwd1_hit=1, fwd1_data=0xB; rs2=7 -> fwd2_hit=0, fwd2_data=0.
REQ-038 x0 drop: push rd0 data 0xDEADBEEF -> count stays 0, no wen; rs1=0 -> fwd1_hit=0.
REQ-039 Wrap and concurrency: DEPTH=4, continuous push plus drain for 10 entries -> count is constant at 1 during steady state, with 10 wen pulses carrying data in order.
REQ-040 Async reset: assert rst mid-cycle with count=3 -> count=0 and wen=0 before the next edge; no stale pulses after release.
